mem_port_arb: RTL and testbench

//  Arbitrates the single-port data RAM between the CPU MEM stage (driven from EX/MEM pipeline regs)
//  and the host loader/debug port. Sequences each access through a small FSM, handles RAM read

---
 rtl/mem_port_arb.sv | 119 +++++++++++
 tb/tb_mem_port_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Arbitrates the single-port data RAM between the CPU MEM stage and the host loader/debug port.
// Latency: grant in cycle 0, RAM strobe in cycle 1; write ack in cycle 1, read ack in cycle 2+RD_LAT.
// Backpressure: cpu_stall freezes the pipeline until cpu_ack; host holds its request until host_ack.
module mem_port_arb #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] wait_cnt;
    logic          owner_host;
    logic          lat_we;
    logic          any_req;
    logic          host_win;
    logic          wait_last;

    // Host only beats a waiting CPU once the CPU has won STARVE_MAX times in a row.
    assign any_req   = cpu_req | host_req;
    assign host_win  = host_req & (~cpu_req | (starve_cnt == STARVE_LIM));
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign ram_we    = lat_we;
    assign cpu_stall = cpu_req & ~cpu_ack;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: IDLE -> ACCESS -> (write) IDLE | (read) WAIT -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = lat_we ? S_IDLE : S_WAIT;
            S_WAIT:   if (wait_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state/owner: strobe in ACCESS, ack on write ACCESS or DONE.
    always_comb begin
        ram_en   = 1'b0;
        cpu_ack  = 1'b0;
        host_ack = 1'b0;
        if (state == S_ACCESS) ram_en = 1'b1;
        if ((state == S_ACCESS && lat_we) || state == S_DONE) begin
            cpu_ack  = ~owner_host;
            host_ack = owner_host;
        end
    end

    // Grant latch, starvation counter, read-latency counter and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_host <= 1'b0;
            lat_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                owner_host <= host_win;
                lat_we     <= host_win ? host_we    : cpu_we;
                ram_addr   <= host_win ? host_addr  : cpu_addr;
                ram_wdata  <= host_win ? host_wdata : cpu_wdata;
                if (host_win) begin
                    starve_cnt <= '0;
                end else if (host_req && starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (state == S_ACCESS) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == S_WAIT && wait_last) begin
                if (owner_host) host_rdata <= ram_rdata;
                else            cpu_rdata  <= ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: per-cycle vector table plus starvation, reset and long-latency sequences.
// Two instances: RD_LAT=1 (main) and RD_LAT=3, each with its own behavioural RAM.
// RAM models drive 0xEE whenever read data is not due, so wrong sampling cycles show up as bad data.
module tb_mem_port_arb;
    logic       clk;
    logic       rst;
    logic       cpu_req, cpu_we, host_req, host_we;
    logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic [7:0] cpu_rdata, host_rdata;
    logic       cpu_ack, cpu_stall, host_ack;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    logic       c3_req, c3_we;
    logic [7:0] c3_addr, c3_wd, c3_rdata, h3_rdata;
    logic       c3_ack, c3_stall, h3_ack;
    logic       ram3_en, ram3_we;
    logic [7:0] ram3_addr, ram3_wd, ram3_rd;

    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] p0, p1, p2;

    int checks = 0;
    int errors = 0;

    mem_port_arb #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    mem_port_arb #(.DATA_W(8), .ADDR_W(8), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wd),
        .cpu_rdata(c3_rdata), .cpu_ack(c3_ack), .cpu_stall(c3_stall),
        .host_req(1'b0), .host_we(1'b0), .host_addr(8'h00), .host_wdata(8'h00),
        .host_rdata(h3_rdata), .host_ack(h3_ack),
        .ram_en(ram3_en), .ram_we(ram3_we), .ram_addr(ram3_addr), .ram_wdata(ram3_wd),
        .ram_rdata(ram3_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RD_LAT=1 RAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (ram_en && ram_we) mem1[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_en && !ram_we) ? mem1[ram_addr] : 8'hEE;
    end

    // RD_LAT=3 RAM: three-stage read pipeline.
    always @(posedge clk) begin
        if (ram3_en && ram3_we) mem3[ram3_addr] <= ram3_wd;
        p0 <= (ram3_en && !ram3_we) ? mem3[ram3_addr] : 8'hEE;
        p1 <= p0;
        p2 <= p1;
    end
    assign ram3_rd = p2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cpu_ack(input int budget, output int cyc);
        cyc = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait3(input int budget, output int cyc, output bit stall_ok);
        cyc      = -1;
        stall_ok = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c3_ack) begin
                cyc = c;
                break;
            end
            if (!c3_stall) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    typedef struct packed {
        logic       rst, creq, cwe;
        logic [7:0] caddr, cwd;
        logic       hreq, hwe;
        logic [7:0] haddr, hwd;
        logic       en, we;
        logic [7:0] addr, wd;
        logic       cack;
        logic [7:0] crd;
        logic       stall, hack;
        logic [7:0] hrd;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        bit   sok;
        int   run;
        int   ngrant;
        logic [36:0] got, want;
        bit   exp_host [11];

        for (int a = 0; a < 256; a++) begin
            mem1[a] = 8'h00;
            mem3[a] = 8'h00;
        end
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        c3_req = 0; c3_we = 0; c3_addr = 0; c3_wd = 0;

        //          rst creq cwe caddr  cwd   hreq hwe haddr  hwd  | en we addr   wd    cack crd   stall hack hrd
        vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00};
        vecs[1]  = '{1, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00};
        vecs[2]  = '{0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00};
        vecs[3]  = '{0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, 1, 8'h00, 0, 0, 8'h00};
        vecs[4]  = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h10, 8'hA5, 0, 8'h00, 1, 0, 8'h00};
        vecs[5]  = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 8'h00, 1, 0, 8'h00};
        vecs[6]  = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h10, 8'h00, 0, 8'h00, 1, 0, 8'h00};
        vecs[7]  = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h10, 8'h00, 1, 8'hA5, 0, 0, 8'h00};
        vecs[8]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 0, 8'h10, 8'h00, 0, 8'hA5, 0, 0, 8'h00};
        vecs[9]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 1, 1, 8'h20, 8'h3C, 0, 8'hA5, 0, 1, 8'h00};
        vecs[10] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 8'h20, 8'h3C, 0, 8'hA5, 0, 0, 8'h00};
        vecs[11] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 8'h20, 8'h00, 0, 8'hA5, 0, 0, 8'h00};
        vecs[12] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00, 0, 8'hA5, 0, 0, 8'h00};
        vecs[13] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00, 0, 8'hA5, 0, 1, 8'h3C};
        vecs[14] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h20, 8'h00, 0, 8'hA5, 0, 0, 8'h3C};
        vecs[15] = '{0, 1, 1, 8'h30, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 0, 8'h20, 8'h00, 0, 8'hA5, 1, 0, 8'h3C};
        vecs[16] = '{0, 0, 1, 8'h31, 8'hFF, 0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h5A, 1, 8'hA5, 0, 0, 8'h3C};
        vecs[17] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h30, 8'h5A, 0, 8'hA5, 0, 0, 8'h3C};

        // Per-cycle table: reset, CPU store/load, host write/read, request dropped after grant.
        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;
            cpu_req = vecs[i].creq;   cpu_we = vecs[i].cwe;
            cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            host_req = vecs[i].hreq;  host_we = vecs[i].hwe;
            host_addr = vecs[i].haddr; host_wdata = vecs[i].hwd;
            @(negedge clk);
            got  = {ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_rdata, cpu_stall, host_ack, host_rdata};
            want = {vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].cack, vecs[i].crd,
                    vecs[i].stall, vecs[i].hack, vecs[i].hrd};
            chk($sformatf("vec%0d", i), 64'(got), 64'(want));
            @(posedge clk); #1;
        end

        // Starvation: both sides request stores continuously; host forced after four CPU wins.
        exp_host = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
        host_req = 1; host_we = 1; host_addr = 8'h41; host_wdata = 8'h22;
        run = 0;
        ngrant = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            chk("ack_exclusive", 64'(cpu_ack & host_ack), 64'd0);
            if ((cpu_ack || host_ack) && ngrant < 11) begin
                chk($sformatf("grant%0d_host", ngrant), 64'(host_ack), 64'(exp_host[ngrant]));
                if (host_ack) run = 0;
                else          run++;
                chk($sformatf("grant%0d_starve", ngrant), 64'(dut.starve_cnt), 64'(run));
                ngrant++;
            end
            @(posedge clk); #1;
        end
        chk("grant_count", 64'(ngrant), 64'd11);
        cpu_req = 0; host_req = 0;

        // Reset during WAIT of a CPU load: no ack, state cleared; the re-issued load then completes.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rst_outputs", 64'({ram_en, cpu_ack, host_ack, cpu_rdata, host_rdata}), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd1);
        chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_no_ack", 64'({cpu_ack, ram_en}), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        wait_cpu_ack(10, cyc);
        chk("rst_recover_cycle", 64'(cyc), 64'd3);
        chk("rst_recover_rdata", 64'(cpu_rdata), 64'hA5);
        @(posedge clk); #1;
        cpu_req = 0;

        // RD_LAT=3 instance: store then load; load ack lands in cycle 5.
        c3_req = 1; c3_we = 1; c3_addr = 8'h10; c3_wd = 8'hA5;
        wait3(10, cyc, sok);
        chk("lat3_store_cycle", 64'(cyc), 64'd1);
        chk("lat3_store_stall", 64'(c3_stall), 64'd0);
        @(posedge clk); #1;
        c3_we = 0; c3_wd = 8'h00;
        wait3(12, cyc, sok);
        chk("lat3_load_cycle", 64'(cyc), 64'd5);
        chk("lat3_load_rdata", 64'(c3_rdata), 64'hA5);
        chk("lat3_stall_held", 64'(sok), 64'd1);
        chk("lat3_host_idle", 64'({h3_ack, h3_rdata}), 64'd0);
        @(posedge clk); #1;
        c3_req = 0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
